fb_access_scheduler: RTL
========================

Name: fb_access_scheduler

Overview:
- Owns both ports of the 1024-byte text framebuffer RAM between textEngine (writer) and the OLED driver (reader).
- Generates the paced read address stream the OLED driver consumes.
- Arbitrates the write port between textEngine byte writes and an internal clear-screen engine.
- Holds one textEngine write that arrives during a clear and replays it afterwards; flags any further writes that are lost.

Parameters:
- ADDR_W, 14, RAM address width
- DATA_W, 8, RAM data width
- FB_BYTES, 1024, framebuffer size; the last address is FB_BYTES-1
- READ_PACE, 18, clk cycles per read address while oled_r_en is high; must be >= 2
- CLR_DATA, 8'h00, byte written by the clear engine

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- te_w_en  in  1  textEngine write strobe, one cycle per byte
- te_w_addr  in  ADDR_W  textEngine write address
- te_w_data  in  DATA_W  textEngine write data
- clr_req  in  1  single-cycle request to clear the framebuffer
- oled_r_en  in  1  OLED driver is streaming and wants reads
- ram_w_en  out  1  RAM write enable, registered
- ram_w_addr  out  ADDR_W  RAM write address, registered
- ram_w_data  out  DATA_W  RAM write data, registered
- ram_r_addr  out  ADDR_W  RAM read address, registered
- clr_busy  out  1  clear in progress
- frame_done  out  1  one-cycle pulse when the read address wraps
- wr_overflow  out  1  sticky: a textEngine write was dropped

Behaviour:
Reset:
- rst_n low asynchronously forces all outputs to 0, pace counter to 0, state to IDLE and the hold register to empty.
- Reset mid-clear abandons the clear; no resume.

Read sequencer:
- While oled_r_en=1, pace_cnt counts 0..READ_PACE-1.
- In the cycle pace_cnt==READ_PACE-1: pace_cnt<=0 and ram_r_addr<=ram_r_addr+1.
- If ram_r_addr==FB_BYTES-1 in that cycle: ram_r_addr<=0 and frame_done=1 for the next cycle only.
- While oled_r_en=0: pace_cnt and ram_r_addr hold; no restart.
- The read sequencer is independent of the write FSM; a clear does not stall reads.

Write FSM states: IDLE, CLEAR, REPLAY.
- IDLE:
  - te_w_en=1: next cycle ram_w_en=1 with the captured address and data (1-cycle latency).
  - clr_req=1: go to CLEAR; clr_busy=1 from the next cycle; clr_addr<=0.
  - te_w_en and clr_req in the same cycle: the te write is issued first (next cycle) and the clear starts the cycle after, so the clear overwrites it. This is deliberate.
- CLEAR:
  - Every cycle: ram_w_en=1, ram_w_addr=clr_addr, ram_w_data=CLR_DATA, then clr_addr++.
  - After writing FB_BYTES-1: clr_busy<=0; go to REPLAY if the hold register is full, else IDLE.
  - Total clear length is exactly FB_BYTES write cycles.
  - clr_req during CLEAR or REPLAY is ignored.
  - te_w_en during CLEAR: if the hold register is empty, capture address and data into it. If it is full, drop the write and set wr_overflow=1.
- REPLAY:
  - One cycle: ram_w_en=1 with the held address and data; hold becomes empty; go to IDLE.
  - A te_w_en arriving in the REPLAY cycle is captured into the hold register, which is refilled in the same cycle it is drained, and is issued from IDLE next cycle. No loss.
- wr_overflow clears only on reset.
- ram_w_en is 0 in any cycle with no write; ram_w_addr and ram_w_data hold their last values.
- Address width: clr_addr is ADDR_W bits; only 0..FB_BYTES-1 is ever driven. te_w_addr is passed through unchecked.

Test Plan:
- Reset then oled_r_en=1 for 18*1024 cycles -> ram_r_addr steps every 18 cycles 0..1023, wraps to 0; exactly one frame_done pulse, in the cycle after the wrap.
- oled_r_en toggled low for 50 cycles at pace_cnt=7, addr=5 -> on resume, addr stays 5 for 11 more cycles, then becomes 6.
- te_w_en with addr=0x010, data=0x41 in IDLE -> next cycle ram_w_en=1, addr 0x010, data 0x41; the cycle after, ram_w_en=0.
- clr_req pulse -> 1024 consecutive writes of 0x00 to addresses 0..1023; clr_busy high for exactly 1024 cycles; then IDLE.
- During a clear: te writes (0x020, 0x42) then (0x021, 0x43) -> 0x42 replayed at 0x020 right after address 1023 is written; 0x43 dropped; wr_overflow=1 until reset.
- rst_n asserted at clear address 500 -> all outputs 0 immediately; after release, IDLE with no further clear writes and the read address at 0.

Source files
------------

// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler
//   Owns both ports of the text framebuffer RAM. The read port is a paced
//   address stream for the OLED driver. The write port is shared between
//   textEngine byte writes and a clear-screen engine. One textEngine write
//   that arrives during a clear is held and replayed afterwards.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   te_w_en/te_w_addr/te_w_data   textEngine write strobe, address, data
//   clr_req                       single-cycle clear request
//   oled_r_en                     OLED driver wants the read stream
//   ram_w_en/ram_w_addr/ram_w_data  registered RAM write port
//   ram_r_addr                    registered RAM read address
//   clr_busy                      clear in progress
//   frame_done                    one-cycle pulse after the read address wraps
//   wr_overflow                   sticky flag: a textEngine write was dropped
module fb_access_scheduler #(
   parameter int              ADDR_W    = 14,
   parameter int              DATA_W    = 8,
   parameter int              FB_BYTES  = 1024,
   parameter int              READ_PACE = 18,
   parameter logic [DATA_W-1:0] CLR_DATA = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              te_w_en,
   input  logic [ADDR_W-1:0] te_w_addr,
   input  logic [DATA_W-1:0] te_w_data,
   input  logic              clr_req,
   input  logic              oled_r_en,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_w_addr,
   output logic [DATA_W-1:0] ram_w_data,
   output logic [ADDR_W-1:0] ram_r_addr,
   output logic              clr_busy,
   output logic              frame_done,
   output logic              wr_overflow
);

   localparam int              PACE_W    = $clog2(READ_PACE);
   localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(READ_PACE - 1);
   localparam logic [ADDR_W-1:0] FB_LAST   = ADDR_W'(FB_BYTES - 1);

   // ---------------- read sequencer ----------------
   logic [PACE_W-1:0] pace_cnt;
   logic              pace_hit;

   assign pace_hit = oled_r_en && (pace_cnt == PACE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pace_cnt   <= '0;
         ram_r_addr <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pace_hit && (ram_r_addr == FB_LAST);
         if (oled_r_en) begin
            if (pace_hit) begin
               pace_cnt   <= '0;
               ram_r_addr <= (ram_r_addr == FB_LAST) ? '0 : ram_r_addr + ADDR_W'(1);
            end else begin
               pace_cnt <= pace_cnt + PACE_W'(1);
            end
         end
      end
   end

   // ---------------- write FSM ----------------
   typedef enum logic [1:0] {IDLE, CLEAR, REPLAY} state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] clr_addr, clr_addr_d;
   logic              hold_vld, hold_vld_d;
   logic [ADDR_W-1:0] hold_addr, hold_addr_d;
   logic [DATA_W-1:0] hold_data, hold_data_d;
   logic              w_en_d, busy_d, ovf_d;
   logic [ADDR_W-1:0] w_addr_d;
   logic [DATA_W-1:0] w_data_d;

   always_comb begin
      state_d     = state;
      clr_addr_d  = clr_addr;
      hold_vld_d  = hold_vld;
      hold_addr_d = hold_addr;
      hold_data_d = hold_data;
      w_en_d      = 1'b0;
      w_addr_d    = ram_w_addr;
      w_data_d    = ram_w_data;
      busy_d      = clr_busy;
      ovf_d       = wr_overflow;
      case (state)
         IDLE: begin
            // A write refilled into the hold during REPLAY drains here; a new
            // te write in this same cycle takes its place in the hold.
            if (hold_vld) begin
               w_en_d     = 1'b1;
               w_addr_d   = hold_addr;
               w_data_d   = hold_data;
               hold_vld_d = te_w_en;
               if (te_w_en) begin
                  hold_addr_d = te_w_addr;
                  hold_data_d = te_w_data;
               end
            end else if (te_w_en) begin
               w_en_d   = 1'b1;
               w_addr_d = te_w_addr;
               w_data_d = te_w_data;
            end
            // A simultaneous te write goes out first; the clear then overwrites it.
            if (clr_req) begin
               state_d    = CLEAR;
               busy_d     = 1'b1;
               clr_addr_d = '0;
            end
         end
         CLEAR: begin
            w_en_d     = 1'b1;
            w_addr_d   = clr_addr;
            w_data_d   = CLR_DATA;
            clr_addr_d = clr_addr + ADDR_W'(1);
            if (te_w_en) begin
               if (!hold_vld) begin
                  hold_vld_d  = 1'b1;
                  hold_addr_d = te_w_addr;
                  hold_data_d = te_w_data;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            // hold_vld_d so a write captured on the final clear cycle still replays
            if (clr_addr == FB_LAST) begin
               busy_d  = 1'b0;
               state_d = hold_vld_d ? REPLAY : IDLE;
            end
         end
         REPLAY: begin
            w_en_d     = 1'b1;
            w_addr_d   = hold_addr;
            w_data_d   = hold_data;
            hold_vld_d = te_w_en;
            if (te_w_en) begin
               hold_addr_d = te_w_addr;
               hold_data_d = te_w_data;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         clr_addr    <= '0;
         hold_vld    <= 1'b0;
         hold_addr   <= '0;
         hold_data   <= '0;
         ram_w_en    <= 1'b0;
         ram_w_addr  <= '0;
         ram_w_data  <= '0;
         clr_busy    <= 1'b0;
         wr_overflow <= 1'b0;
      end else begin
         state       <= state_d;
         clr_addr    <= clr_addr_d;
         hold_vld    <= hold_vld_d;
         hold_addr   <= hold_addr_d;
         hold_data   <= hold_data_d;
         ram_w_en    <= w_en_d;
         ram_w_addr  <= w_addr_d;
         ram_w_data  <= w_data_d;
         clr_busy    <= busy_d;
         wr_overflow <= ovf_d;
      end
   end

endmodule
